// File: rtl/fifoxa.sv
// rtl/fifoxa.sv - register-based synchronous FIFO with FWFT, almost flags, flush and sticky errors
//
// Purpose: small datapath buffer (up to 64 entries) built from flops. Supports any depth
//          2..2^ADDRBIT, registered or show-ahead output, programmable almost-full/empty
//          thresholds, synchronous flush, write-while-full when a read frees a slot in the
//          same cycle, and sticky overflow/underflow indicators.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (clears array, pointers, flags)
//   flush     in   synchronous clear of pointers, level, error flags and registered output
//   fifowr    in   write request
//   fifodin   in   write data [WIDTH]
//   fiford    in   read request
//   fifodout  out  read data [WIDTH] (registered when FWFT=0, head word when FWFT=1)
//   notempty  out  fill level != 0
//   fifofull  out  fill level == LENGTH
//   afull     out  fill level >= AFULL_TH
//   aempty    out  fill level <= AEMPT_TH
//   fifolen   out  fill level [ADDRBIT+1]
//   ovf       out  sticky overflow
//   udf       out  sticky underflow
module fifoxa #(
  parameter int ADDRBIT          = 4,
  parameter int LENGTH           = 16,
  parameter int WIDTH            = 8,
  parameter bit FWFT             = 1'b0,
  parameter bit FIFODOUT_NOLATCH = 1'b1,
  parameter int AFULL_TH         = LENGTH - 2,
  parameter int AEMPT_TH         = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fifowr,
  input  logic [WIDTH-1:0]   fifodin,
  input  logic               fiford,
  output logic [WIDTH-1:0]   fifodout,
  output logic               notempty,
  output logic               fifofull,
  output logic               afull,
  output logic               aempty,
  output logic [ADDRBIT:0]   fifolen,
  output logic               ovf,
  output logic               udf
);

  localparam logic [ADDRBIT-1:0] PTR_LAST = ADDRBIT'(LENGTH - 1);
  localparam logic [ADDRBIT:0]   LEN_FULL = (ADDRBIT+1)'(LENGTH);

  logic [WIDTH-1:0]   mem_q [LENGTH];
  logic [WIDTH-1:0]   mem_d [LENGTH];
  logic [ADDRBIT-1:0] wrptr_q, wrptr_d;
  logic [ADDRBIT-1:0] rdptr_q, rdptr_d;
  logic [ADDRBIT:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               rd_ok;
  logic               wr_ok;

  // Status depends only on the registered level.
  assign notempty = (len_q != '0);
  assign fifofull = (len_q == LEN_FULL);
  assign afull    = (int'(len_q) >= AFULL_TH);
  assign aempty   = (int'(len_q) <= AEMPT_TH);
  assign fifolen  = len_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign rd_ok = fiford & notempty;
  assign wr_ok = fifowr & (~fifofull | rd_ok);

  always_comb begin
    mem_d   = mem_q;
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    dout_d  = dout_q;
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      dout_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wrptr_q] = fifodin;
        wrptr_d = (wrptr_q == PTR_LAST) ? '0 : wrptr_q + ADDRBIT'(1);
      end
      if (rd_ok) begin
        rdptr_d = (rdptr_q == PTR_LAST) ? '0 : rdptr_q + ADDRBIT'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   len_d = len_q + (ADDRBIT+1)'(1);
        2'b01:   len_d = len_q - (ADDRBIT+1)'(1);
        default: len_d = len_q;
      endcase
      ovf_d = ovf_q | (fifowr & fifofull & ~rd_ok);
      // No empty bypass: a read of an empty FIFO is an underflow even with a write present.
      udf_d = udf_q | (fiford & ~notempty);
      if (rd_ok) begin
        dout_d = mem_q[rdptr_q];
      end else if (FIFODOUT_NOLATCH) begin
        dout_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) begin
        mem_q[i] <= '0;
      end
      wrptr_q <= '0;
      rdptr_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dout_q  <= dout_d;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign fifodout = notempty ? mem_q[rdptr_q] : '0;
    end else begin : g_reg
      assign fifodout = dout_q;
    end
  endgenerate

endmodule
